// File: rtl/rv_mem_pkg.sv
// Shared types for the core memory-port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the in-flight transaction
//   STARVE_W: width of the IFU starvation counter
package rv_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic {
        OwnIfu,
        OwnLsu
    } owner_e;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/rv_mem_timeout.sv
// Transaction timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count (at grant)
//   en_i       : count this cycle (transaction in flight)
//   expire_o   : count has reached TIMEOUT-1 while enabled
// TIMEOUT=0 disables the timeout: expire_o is tied low.
module rv_mem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_tmo;
        assign unused_tmo = ^{clk, rst_n, clr_i, en_i};
        assign expire_o   = 1'b0;
    end else begin : g_on
        localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && cnt_q != LastCnt) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expire_o = en_i && (cnt_q == LastCnt);
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares the single external memory port between the IFU (read-only) and
// the LSU (read/write). One transaction in flight; LSU has fixed priority
// except when the IFU has lost MAX_STARVE arbitrations in a row.
//   ifu_*  : IFU request/grant/response
//   lsu_*  : LSU request/grant/response (lsu_we_i=1 is a write)
//   mem_*  : external memory interface, addr/wdata/we registered
//   busy_o : FSM not idle
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_req_i,
    input  logic [AW-1:0] ifu_addr_i,
    output logic          ifu_gnt_o,
    output logic          ifu_rvalid_o,
    output logic [DW-1:0] ifu_rdata_o,
    output logic          ifu_err_o,
    input  logic          lsu_req_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [DW-1:0] lsu_wdata_i,
    input  logic          lsu_we_i,
    output logic          lsu_gnt_o,
    output logic          lsu_rvalid_o,
    output logic [DW-1:0] lsu_rdata_o,
    output logic          lsu_err_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    input  logic          mem_ready_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                we_q, we_d;

    logic ifu_win;
    logic tmo_clr, tmo_expire;
    logic resp_valid, resp_err;

    // IFU wins outright when alone, or when it has been starved long enough.
    assign ifu_win = ifu_req_i && (!lsu_req_i || starve_q == STARVE_W'(MAX_STARVE));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        ifu_gnt_o  = 1'b0;
        lsu_gnt_o  = 1'b0;
        mem_req_o  = 1'b0;
        tmo_clr    = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ifu_win) begin
                    ifu_gnt_o = 1'b1;
                    owner_d   = OwnIfu;
                    addr_d    = ifu_addr_i;
                    wdata_d   = '0;
                    we_d      = 1'b0;
                    starve_d  = '0;
                    tmo_clr   = 1'b1;
                    state_d   = StIssue;
                end else if (lsu_req_i) begin
                    lsu_gnt_o = 1'b1;
                    owner_d   = OwnLsu;
                    addr_d    = lsu_addr_i;
                    wdata_d   = lsu_wdata_i;
                    we_d      = lsu_we_i;
                    tmo_clr   = 1'b1;
                    state_d   = StIssue;
                    if (ifu_req_i && starve_q != '1) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                // A response cannot arrive before acceptance, so only the timeout ends ISSUE early.
                if (tmo_expire) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = StIdle;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Completion takes precedence over a coincident timeout.
                if (mem_rvalid_i) begin
                    resp_valid = 1'b1;
                    state_d    = StIdle;
                end else if (tmo_expire) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ifu_rvalid_o = resp_valid && (owner_q == OwnIfu);
    assign lsu_rvalid_o = resp_valid && (owner_q == OwnLsu);
    assign ifu_err_o    = ifu_rvalid_o && resp_err;
    assign lsu_err_o    = lsu_rvalid_o && resp_err;
    assign ifu_rdata_o  = (ifu_rvalid_o && !resp_err) ? mem_rdata_i : '0;
    assign lsu_rdata_o  = (lsu_rvalid_o && !resp_err) ? mem_rdata_i : '0;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = we_q;
    assign busy_o       = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= OwnIfu;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    rv_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (state_q != StIdle),
        .expire_o (tmo_expire)
    );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .MAX_STARVE (4),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifu_req_i    (ifu_req),
        .ifu_addr_i   (ifu_addr),
        .ifu_gnt_o    (ifu_gnt),
        .ifu_rvalid_o (ifu_rvalid),
        .ifu_rdata_o  (ifu_rdata),
        .ifu_err_o    (ifu_err),
        .lsu_req_i    (lsu_req),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_we_i     (lsu_we),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_err_o    (lsu_err),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_ready_i  (mem_ready),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // From the cycle a grant was issued: ready next cycle, response the one after,
    // return at the following IDLE cycle.
    task automatic serve(input logic [31:0] rdata);
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        step(); mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        logic [1:0] gnt_exp;
        rst_n = 1'b0;
        ifu_req = 0; ifu_addr = '0;
        lsu_req = 0; lsu_addr = '0; lsu_wdata = '0; lsu_we = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset state
        step(); settle();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_gnt", {30'd0, ifu_gnt, lsu_gnt}, 0);
        step(); rst_n = 1'b1;

        // IFU read, minimum latency
        step(); ifu_req = 1; ifu_addr = 32'h100; settle();
        check("t1_ifu_gnt", 32'(ifu_gnt), 1);
        check("t1_busy_c0", 32'(busy), 0);
        step(); ifu_req = 0; mem_ready = 1; settle();
        check("t1_mem_req", 32'(mem_req), 1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_we", 32'(mem_we), 0);
        step(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; settle();
        check("t1_ifu_rvalid", 32'(ifu_rvalid), 1);
        check("t1_ifu_rdata", ifu_rdata, 32'hDEADBEEF);
        check("t1_ifu_err", 32'(ifu_err), 0);
        check("t1_lsu_rvalid", 32'(lsu_rvalid), 0);
        check("t1_mem_req_c2", 32'(mem_req), 0);
        step(); mem_rvalid = 0; mem_rdata = '0; settle();
        check("t1_busy_c3", 32'(busy), 0);

        // Simultaneous: LSU write first, IFU afterwards
        ifu_req = 1; ifu_addr = 32'h300;
        lsu_req = 1; lsu_addr = 32'h200; lsu_wdata = 32'h1234; lsu_we = 1; settle();
        check("t2_gnt_c0", {30'd0, ifu_gnt, lsu_gnt}, 32'b01);
        step(); lsu_req = 0; lsu_we = 0; mem_ready = 1; settle();
        check("t2_mem_we", 32'(mem_we), 1);
        check("t2_mem_wdata", mem_wdata, 32'h1234);
        check("t2_mem_addr", mem_addr, 32'h200);
        check("t2_no_ifu_gnt", 32'(ifu_gnt), 0);
        step(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0; settle();
        check("t2_lsu_ack", 32'(lsu_rvalid), 1);
        check("t2_ifu_rvalid", 32'(ifu_rvalid), 0);
        step(); mem_rvalid = 0; settle();
        check("t2_ifu_gnt", 32'(ifu_gnt), 1);
        step(); ifu_req = 0; mem_ready = 1; settle();
        check("t2_ifu_addr", mem_addr, 32'h300);
        check("t2_ifu_we", 32'(mem_we), 0);
        check("t2_ifu_wdata", mem_wdata, 0);
        step(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h5A5A; settle();
        check("t2_ifu_rdata", ifu_rdata, 32'h5A5A);
        step(); mem_rvalid = 0; mem_rdata = '0;

        // Starvation guard: both requesting continuously, expect L,L,L,L,I x2
        ifu_req = 1; ifu_addr = 32'h1000;
        lsu_req = 1; lsu_addr = 32'h2000; lsu_we = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            gnt_exp = (i % 5 == 4) ? 2'b10 : 2'b01;
            check($sformatf("t3_grant%0d", i), {30'd0, ifu_gnt, lsu_gnt}, {30'd0, gnt_exp});
            serve(32'h0);
        end
        ifu_req = 0; lsu_req = 0;

        // mem_ready withheld for 3 cycles; LSU must wait
        step(); ifu_req = 1; ifu_addr = 32'h400; settle();
        check("t4_ifu_gnt", 32'(ifu_gnt), 1);
        step(); ifu_req = 0; lsu_req = 1; lsu_addr = 32'h500; lsu_we = 1; lsu_wdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t4_mem_req%0d", i), 32'(mem_req), 1);
            check($sformatf("t4_mem_addr%0d", i), mem_addr, 32'h400);
            check($sformatf("t4_no_lsu_gnt%0d", i), 32'(lsu_gnt), 0);
            step();
        end
        mem_ready = 1; settle();
        check("t4_mem_req_rdy", 32'(mem_req), 1);
        step(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE; settle();
        check("t4_ifu_rdata", ifu_rdata, 32'hCAFE);
        step(); mem_rvalid = 0; settle();
        check("t4_lsu_gnt", 32'(lsu_gnt), 1);
        serve(32'h0);
        lsu_req = 0; lsu_we = 0;

        // Timeout: LSU read, memory never responds
        step(); lsu_req = 1; lsu_addr = 32'h600; settle();
        check("t5_lsu_gnt", 32'(lsu_gnt), 1);
        step(); lsu_req = 0; mem_ready = 1; mem_rdata = 32'hAAAA;
        step(); mem_ready = 0;
        for (int c = 2; c < 8; c++) begin
            settle();
            check($sformatf("t5_no_rvalid_c%0d", c), 32'(lsu_rvalid), 0);
            step();
        end
        settle();
        check("t5_tmo_rvalid", 32'(lsu_rvalid), 1);
        check("t5_tmo_err", 32'(lsu_err), 1);
        check("t5_tmo_rdata", lsu_rdata, 0);
        check("t5_tmo_mem_req", 32'(mem_req), 0);
        step(); settle();
        check("t5_busy_after", 32'(busy), 0);

        // Completion in the timeout cycle wins
        lsu_req = 1; lsu_addr = 32'h680; settle();
        check("t5b_lsu_gnt", 32'(lsu_gnt), 1);
        step(); lsu_req = 0; mem_ready = 1;
        step(); mem_ready = 0;
        for (int c = 2; c < 8; c++) step();
        mem_rvalid = 1; mem_rdata = 32'h55; settle();
        check("t5b_rvalid", 32'(lsu_rvalid), 1);
        check("t5b_err", 32'(lsu_err), 0);
        check("t5b_rdata", lsu_rdata, 32'h55);
        step(); mem_rvalid = 0; mem_rdata = '0;

        // Reset while in WAIT
        step(); ifu_req = 1; ifu_addr = 32'h700;
        step(); ifu_req = 0; mem_ready = 1;
        step(); mem_ready = 0; settle();
        check("t6_busy_wait", 32'(busy), 1);
        rst_n = 0; settle();
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_mem_req", 32'(mem_req), 0);
        check("t6_rst_rvalid", 32'(ifu_rvalid), 0);
        step(); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h99; settle();
        check("t6_ignored_rvalid", 32'(ifu_rvalid), 0);
        check("t6_ignored_busy", 32'(busy), 0);
        step(); mem_rvalid = 0; mem_rdata = '0; ifu_req = 1; ifu_addr = 32'h800; settle();
        check("t6_new_gnt", 32'(ifu_gnt), 1);
        step(); ifu_req = 0; mem_ready = 1; settle();
        check("t6_new_addr", mem_addr, 32'h800);
        step(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1357; settle();
        check("t6_new_rdata", ifu_rdata, 32'h1357);
        step(); mem_rvalid = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares the core's single external memory port between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Allows one outstanding transaction at a time.
- Fixed LSU priority, with a starvation guard for IFU and a response timeout.
- Sits between the core pipeline and the addr/dataout/datain/we memory interface.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STARVE, 4, consecutive LSU grants while IFU waits before IFU is forced to win (1..15)
TIMEOUT, 255, cycles in ISSUE+WAIT before aborting; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req  in  1  IFU read request; must hold with stable ifu_addr until ifu_gnt
ifu_addr  in  AW  IFU read address
ifu_gnt  out  1  IFU request accepted (1-cycle pulse)
ifu_rvalid  out  1  IFU response valid (1-cycle pulse)
ifu_rdata  out  DW  IFU read data, valid with ifu_rvalid
ifu_err  out  1  IFU response is a timeout abort, valid with ifu_rvalid
lsu_req  in  1  LSU request; must hold with stable addr/wdata/we until lsu_gnt
lsu_addr  in  AW  LSU address
lsu_wdata  in  DW  LSU write data
lsu_we  in  1  1 = write, 0 = read
lsu_gnt  out  1  LSU request accepted (1-cycle pulse)
lsu_rvalid  out  1  LSU response/write-ack (1-cycle pulse)
lsu_rdata  out  DW  LSU read data, valid with lsu_rvalid
lsu_err  out  1  LSU timeout abort, valid with lsu_rvalid
mem_req  out  1  memory request valid
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_we  out  1  memory write enable (registered)
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response/ack
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, owner=IFU, starve_cnt=0, tmo_cnt=0; all outputs 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, grant selection:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both request: LSU wins unless starve_cnt==MAX_STARVE, in which case IFU wins.
- IDLE, on grant: the winner's gnt is driven combinationally in the same cycle. At that edge, addr/wdata/we are captured (IFU: wdata=0, we=0), owner is recorded, and the FSM goes to ISSUE.
- starve_cnt:
  - +1 (saturating) when LSU is granted while ifu_req=1.
  - Cleared when IFU is granted.
  - Unchanged when LSU is granted with ifu_req=0.
- ISSUE: mem_req=1 with stable registered addr/wdata/we. On mem_ready=1, go to WAIT at the next edge; mem_req drops.
- WAIT: on mem_rvalid=1, the owner's rvalid pulses combinationally with rdata=mem_rdata and err=0, then the FSM returns to IDLE.
  - Non-owner rvalid and rdata stay 0.
  - Writes complete the same way (ack via rvalid).
- mem_rvalid outside WAIT is ignored. mem_rvalid in the same cycle as mem_ready (ISSUE) is ignored.
- Minimum latency: req@c0 (gnt c0), mem_req@c1, mem_ready@c1, mem_rvalid@c2 -> rvalid c2. Next grant no earlier than c3.
- Timeout (TIMEOUT>0):
  - tmo_cnt clears on grant and increments every cycle in ISSUE/WAIT.
  - When tmo_cnt==TIMEOUT-1 and no completion occurs that cycle: the owner's rvalid=1 and err=1 with rdata=0; mem_req drops; the FSM goes to IDLE.
  - Completion in the same cycle wins over timeout (err=0).
- Requester drops req before gnt: legal, no grant issued.
- Reset mid-transaction: immediate return to IDLE, no response delivered.

Decomposition:
- Shared package rv_mem_pkg:
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_IFU, OWN_LSU}
  - localparam STARVE_W=4
- One sub-module, rv_mem_timeout: cycle counter with clear/enable inputs and an expire output, parameterised by TIMEOUT. TIMEOUT=0 ties expire to 0.

Test Plan:
- IFU read only, addr 0x100, mem_ready same cycle, mem_rvalid next cycle with 0xDEADBEEF -> ifu_gnt c0, mem_req c1, ifu_rvalid c2 with rdata 0xDEADBEEF, err=0.
- Simultaneous ifu_req and lsu_req (LSU write 0x200 <- 0x1234) -> LSU granted first, mem_we=1, mem_wdata=0x1234, lsu_rvalid ack; IFU granted on the following IDLE.
- LSU requesting continuously and IFU requesting continuously, MAX_STARVE=4 -> grant order L,L,L,L,I,L,L,L,L,I.
- mem_ready held 0 for 3 cycles in ISSUE -> mem_req and mem_addr stable throughout, no gnt to the other requester.
- TIMEOUT=8, memory never responds to an LSU read -> lsu_rvalid=1, lsu_err=1, rdata=0 on the 8th cycle after grant; busy=0 the next cycle.
- rst_n asserted while in WAIT -> all outputs 0 immediately; a subsequent mem_rvalid is ignored; a new IFU request is granted normally.
